// File: rtl/traffic_light_controller.sv
// Two-road traffic light controller: a six-phase Moore FSM with a shared
// 10-bit phase counter and lamp outputs decoded only from the state register.
module traffic_light_controller #(
    parameter int GREEN_TIME  = 50,
    parameter int YELLOW_TIME = 10,
    parameter int ALLRED_TIME = 5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Terminal count of each phase, i.e. duration-1.
    localparam logic [9:0] GREEN_LAST  = 10'(GREEN_TIME - 1);
    localparam logic [9:0] YELLOW_LAST = 10'(YELLOW_TIME - 1);
    localparam logic [9:0] ALLRED_LAST = 10'(ALLRED_TIME - 1);

    state_t     r_state;
    logic [9:0] r_count;
    logic [9:0] w_last;
    logic       w_illegal;
    logic       w_done;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_last    = '0;
        w_illegal = 1'b0;
        case (r_state)
            NS_GREEN, EW_GREEN:   w_last = GREEN_LAST;
            NS_YELLOW, EW_YELLOW: w_last = YELLOW_LAST;
            ALLRED_A, ALLRED_B:   w_last = ALLRED_LAST;
            default:              w_illegal = 1'b1;
        endcase
    end

    assign w_done = (r_count == w_last);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= NS_GREEN;
            r_count <= '0;
        end else if (w_done || w_illegal) begin
            r_count <= '0;
            case (r_state)
                NS_GREEN:  r_state <= NS_YELLOW;
                NS_YELLOW: r_state <= ALLRED_A;
                ALLRED_A:  r_state <= EW_GREEN;
                EW_GREEN:  r_state <= EW_YELLOW;
                EW_YELLOW: r_state <= ALLRED_B;
                ALLRED_B:  r_state <= NS_GREEN;
                default:   r_state <= ALLRED_B;
            endcase
        end else begin
            r_count <= r_count + 10'd1;
        end
    end

    // Unknown encodings fall through to all-red, the only safe lamp pattern.
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (r_state)
            NS_GREEN:  ns_light = LAMP_GREEN;
            NS_YELLOW: ns_light = LAMP_YELLOW;
            EW_GREEN:  ew_light = LAMP_GREEN;
            EW_YELLOW: ew_light = LAMP_YELLOW;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default timeline, mid-phase and
// held reset, a small-parameter instance, and a per-cycle safety checker.
module tb_traffic_light_controller;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic [2:0] ns_a, ew_a, ns_b, ew_b;
    logic       armed = 1'b0;
    int         n_total = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut_a (
        .clk      (clk),
        .reset    (rst_a),
        .ns_light (ns_a),
        .ew_light (ew_a)
    );

    traffic_light_controller #(
        .GREEN_TIME  (3),
        .YELLOW_TIME (2),
        .ALLRED_TIME (1)
    ) dut_b (
        .clk      (clk),
        .reset    (rst_b),
        .ns_light (ns_b),
        .ew_light (ew_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default timeline: {ns, ew} after edge e counted from the reset edge.
    function automatic logic [5:0] exp_def(input int e);
        int p;
        p = e % 130;
        if (p < 50)       return 6'b001_100;
        else if (p < 60)  return 6'b010_100;
        else if (p < 65)  return 6'b100_100;
        else if (p < 115) return 6'b100_001;
        else if (p < 125) return 6'b100_010;
        else              return 6'b100_100;
    endfunction

    // GREEN=3, YELLOW=2, ALLRED=1: changes at edges 3, 5, 6, 9, 11, 12.
    function automatic logic [5:0] exp_small(input int e);
        int p;
        p = e % 12;
        if (p < 3)       return 6'b001_100;
        else if (p < 5)  return 6'b010_100;
        else if (p < 6)  return 6'b100_100;
        else if (p < 9)  return 6'b100_001;
        else if (p < 11) return 6'b100_010;
        else             return 6'b100_100;
    endfunction

    function automatic logic one_hot(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // Safety: at most one road may be non-red, and every lamp stays one-hot.
    always @(negedge clk) begin
        if (armed) begin
            check("safe_a", 32'((ns_a == 3'b100) || (ew_a == 3'b100)), 32'd1);
            check("onehot_a", 32'(one_hot(ns_a) && one_hot(ew_a)), 32'd1);
            check("safe_b", 32'((ns_b == 3'b100) || (ew_b == 3'b100)), 32'd1);
            check("onehot_b", 32'(one_hot(ns_b) && one_hot(ew_b)), 32'd1);
        end
    end

    initial begin
        // Single-cycle reset on both instances.
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        check("reset_a", 32'({ns_a, ew_a}), 32'(6'b001_100));
        check("reset_b", 32'({ns_b, ew_b}), 32'(6'b001_100));
        armed = 1'b1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Full default timeline through edge 180; small instance over two cycles.
        for (int e = 1; e <= 180; e++) begin
            tick();
            check($sformatf("timeline_e%0d", e), 32'({ns_a, ew_a}), 32'(exp_def(e)));
            if (e <= 24)
                check($sformatf("small_e%0d", e), 32'({ns_b, ew_b}), 32'(exp_small(e)));
        end

        // Fresh reset, then a reset at edge 70 while EW is green.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int e = 1; e <= 69; e++) tick();
        check("pre_mid_reset_ewg", 32'({ns_a, ew_a}), 32'(6'b100_001));
        rst_a = 1'b1;
        tick();
        check("mid_reset", 32'({ns_a, ew_a}), 32'(6'b001_100));
        rst_a = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            check($sformatf("after_mid_e%0d", e), 32'({ns_a, ew_a}), 32'(exp_def(e)));
        end

        // Reset held for 20 cycles, outputs frozen at NS green.
        rst_a = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check($sformatf("held_c%0d", c), 32'({ns_a, ew_a}), 32'(6'b001_100));
        end
        rst_a = 1'b0;
        for (int e = 1; e <= 131; e++) begin
            tick();
            check($sformatf("after_held_e%0d", e), 32'({ns_a, ew_a}), 32'(exp_def(e)));
        end

        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
